// File: rtl/vga_mode_sequencer.sv
// rtl/vga_mode_sequencer.sv - video mode change sequencer for the VGA pixel-clock generator
module vga_mode_sequencer #(
    parameter int NUM_MODES      = 4,
    parameter int DEFAULT_MODE   = 1,
    parameter int DRAIN_CYCLES   = 64,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int SETTLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_33,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [2:0] req_mode,
    output logic       req_ready,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic [2:0] mode_sel,
    output logic       video_rst_n,
    output logic       busy,
    output logic       bad_mode,
    output logic       err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUN       = 3'd1;
    localparam logic [2:0] S_DRAIN     = 3'd2;
    localparam logic [2:0] S_PLL_RST   = 3'd3;
    localparam logic [2:0] S_WAIT_LOCK = 3'd4;
    localparam logic [2:0] S_SETTLE    = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    localparam int MAX_A   = (DRAIN_CYCLES > PLL_RST_CYCLES) ? DRAIN_CYCLES : PLL_RST_CYCLES;
    localparam int MAX_B   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    // Down-counters load "length - 1" and the state exits on the cycle they read zero.
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] PLL_LOAD   = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first locked cycle.
    localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
    localparam logic [2:0]    MODE_MAX     = 3'(NUM_MODES);
    localparam logic [2:0]    MODE_DEFAULT = 3'(DEFAULT_MODE);

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    target, target_nx;
    logic [2:0]    mode_sel_nx;
    logic [RW-1:0] retry, retry_nx, retry_inc;
    logic          bad_mode_nx;
    logic          fail;
    logic          lock_meta, lock_sync;
    logic          req_fire, req_legal;

    assign req_fire  = req_valid && req_ready;
    assign req_legal = (req_mode != 3'd0) && (req_mode <= MODE_MAX);
    assign retry_inc = retry + RW'(1);

    // Two-flop synchroniser for the asynchronous converter lock.
    always_ff @(posedge clk_33) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    // Next-state, counter, target and retry decisions.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        target_nx   = target;
        retry_nx    = retry;
        mode_sel_nx = mode_sel;
        bad_mode_nx = 1'b0;
        fail        = 1'b0;
        case (state)
            S_IDLE, S_RUN: begin
                if (req_fire && !req_legal) begin
                    bad_mode_nx = 1'b1;
                end
                if (req_fire) begin
                    retry_nx = '0;
                end
                if (req_fire && req_legal && (req_mode != mode_sel)) begin
                    state_nx  = S_DRAIN;
                    cnt_nx    = DRAIN_LOAD;
                    target_nx = req_mode;
                end else if (!lock_sync) begin
                    // Lock lost while running: relock the current mode unprompted.
                    state_nx  = S_DRAIN;
                    cnt_nx    = DRAIN_LOAD;
                    target_nx = mode_sel;
                    retry_nx  = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == '0) begin
                    state_nx    = S_PLL_RST;
                    cnt_nx      = PLL_LOAD;
                    mode_sel_nx = target;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_PLL_RST: begin
                if (cnt == '0) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = LOCK_LOAD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_nx = S_SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end else if (cnt == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_SETTLE: begin
                if (!lock_sync) begin
                    fail = 1'b1;
                end else if (cnt == '0) begin
                    state_nx = S_RUN;
                    retry_nx = '0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_ERROR: begin
                if (req_fire) begin
                    retry_nx = '0;
                    if (req_legal) begin
                        state_nx  = S_DRAIN;
                        cnt_nx    = DRAIN_LOAD;
                        target_nx = req_mode;
                    end else begin
                        bad_mode_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_PLL_RST;
                cnt_nx   = PLL_LOAD;
            end
        endcase
        // A failed attempt retries the same target until the retry budget is spent.
        if (fail) begin
            retry_nx = retry_inc;
            if (retry_inc < RETRY_LIMIT) begin
                state_nx    = S_PLL_RST;
                cnt_nx      = PLL_LOAD;
                mode_sel_nx = target;
            end else begin
                state_nx = S_ERROR;
            end
        end
    end

    // State registers; every output is decoded from the next state so it is registered.
    always_ff @(posedge clk_33) begin
        if (!reset_n) begin
            state       <= S_PLL_RST;
            cnt         <= PLL_LOAD;
            target      <= MODE_DEFAULT;
            retry       <= '0;
            mode_sel    <= MODE_DEFAULT;
            pll_rst     <= 1'b1;
            video_rst_n <= 1'b0;
            busy        <= 1'b1;
            req_ready   <= 1'b0;
            bad_mode    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            target      <= target_nx;
            retry       <= retry_nx;
            mode_sel    <= mode_sel_nx;
            pll_rst     <= (state_nx == S_PLL_RST);
            video_rst_n <= (state_nx == S_RUN) || (state_nx == S_IDLE);
            busy        <= !((state_nx == S_RUN) || (state_nx == S_IDLE) || (state_nx == S_ERROR));
            req_ready   <= (state_nx == S_RUN) || (state_nx == S_IDLE) || (state_nx == S_ERROR);
            bad_mode    <= bad_mode_nx;
            err         <= (state_nx == S_ERROR);
        end
    end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb/tb_vga_mode_sequencer.sv - scoreboard bench for vga_mode_sequencer
module tb_vga_mode_sequencer;

    localparam int LT = 300;

    localparam int EV_BAD_RISE = 1;
    localparam int EV_BAD_FALL = 2;
    localparam int EV_ERR_RISE = 3;
    localparam int EV_ERR_FALL = 4;
    localparam int EV_VID_RISE = 5;
    localparam int EV_VID_FALL = 6;
    localparam int EV_PLL_RISE = 7;
    localparam int EV_PLL_FALL = 8;

    typedef struct {
        int kind;
        int cyc;
        int mode;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] mode_sel;
    logic       video_rst_n;
    logic       busy;
    logic       bad_mode;
    logic       err;

    int  vectors    = 0;
    int  miscompares = 0;
    int  cyc        = 0;
    bit  mon_en     = 1'b0;
    ev_t sb[$];
    logic p_bad, p_err, p_vid, p_pll;

    vga_mode_sequencer #(
        .NUM_MODES      (4),
        .DEFAULT_MODE   (1),
        .DRAIN_CYCLES   (64),
        .PLL_RST_CYCLES (16),
        .LOCK_TIMEOUT   (LT),
        .SETTLE_CYCLES  (256),
        .MAX_RETRIES    (3)
    ) dut (
        .clk_33      (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ready   (req_ready),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .mode_sel    (mode_sel),
        .video_rst_n (video_rst_n),
        .busy        (busy),
        .bad_mode    (bad_mode),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int at, input int mode);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.mode = mode;
        sb.push_back(e);
    endtask

    task automatic sb_match(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event", kind, 0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("ev%0d_kind", e.kind), kind, e.kind);
            chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
            chk($sformatf("ev%0d_mode_sel", e.kind), int'(mode_sel), e.mode);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Output monitor: every edge on a watched output must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bad_mode !== p_bad) sb_match(bad_mode ? EV_BAD_RISE : EV_BAD_FALL);
            if (err !== p_err)      sb_match(err ? EV_ERR_RISE : EV_ERR_FALL);
            if (video_rst_n !== p_vid) sb_match(video_rst_n ? EV_VID_RISE : EV_VID_FALL);
            if (pll_rst !== p_pll)  sb_match(pll_rst ? EV_PLL_RISE : EV_PLL_FALL);
        end
        p_bad = bad_mode;
        p_err = err;
        p_vid = video_rst_n;
        p_pll = pll_rst;
    end

    initial begin
        int t;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_mode   = 3'd0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_video_rst_n", int'(video_rst_n), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_bad_mode", int'(bad_mode), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_mode_sel", int'(mode_sel), 1);

        // Bring-up of the default mode, lock 40 cycles after pll_rst falls.
        mon_en  = 1'b1;
        reset_n = 1'b1;
        t = cyc;
        push_ev(EV_PLL_FALL, t + 16, 1);
        wait_to(t + 56);
        pll_locked = 1'b1;
        t = cyc;
        push_ev(EV_VID_RISE, t + 258, 1);
        wait_to(t + 260);
        chk("up_busy", int'(busy), 0);
        chk("up_req_ready", int'(req_ready), 1);
        chk("up_mode_sel", int'(mode_sel), 1);

        // Mode change to 3.
        t = cyc;
        req_valid = 1'b1;
        req_mode  = 3'd3;
        push_ev(EV_VID_FALL, t + 1, 1);
        push_ev(EV_PLL_RISE, t + 65, 3);
        push_ev(EV_PLL_FALL, t + 81, 3);
        push_ev(EV_VID_RISE, t + 337, 3);
        @(negedge clk);
        req_valid = 1'b0;
        chk("acc_busy", int'(busy), 1);
        chk("acc_req_ready", int'(req_ready), 0);
        wait_to(t + 340);
        chk("m3_busy", int'(busy), 0);
        chk("m3_mode_sel", int'(mode_sel), 3);

        // Illegal codes 0 and 5, then a same-mode no-op request.
        t = cyc;
        req_valid = 1'b1;
        req_mode  = 3'd0;
        push_ev(EV_BAD_RISE, t + 1, 3);
        push_ev(EV_BAD_FALL, t + 2, 3);
        @(negedge clk);
        req_valid = 1'b0;
        wait_to(t + 4);
        req_valid = 1'b1;
        req_mode  = 3'd5;
        push_ev(EV_BAD_RISE, t + 5, 3);
        push_ev(EV_BAD_FALL, t + 6, 3);
        @(negedge clk);
        req_valid = 1'b0;
        wait_to(t + 8);
        req_valid = 1'b1;
        req_mode  = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        wait_to(t + 12);
        chk("bad_mode_sel", int'(mode_sel), 3);
        chk("bad_video_rst_n", int'(video_rst_n), 1);
        chk("bad_busy", int'(busy), 0);
        chk("bad_req_ready", int'(req_ready), 1);

        // Lock lost in RUN and never returns: relock mode 3, three pulses, then ERROR.
        t = cyc;
        pll_locked = 1'b0;
        push_ev(EV_VID_FALL, t + 3, 3);
        push_ev(EV_PLL_RISE, t + 67, 3);
        push_ev(EV_PLL_FALL, t + 83, 3);
        push_ev(EV_PLL_RISE, t + 83 + LT, 3);
        push_ev(EV_PLL_FALL, t + 99 + LT, 3);
        push_ev(EV_PLL_RISE, t + 99 + 2 * LT, 3);
        push_ev(EV_PLL_FALL, t + 115 + 2 * LT, 3);
        push_ev(EV_ERR_RISE, t + 115 + 3 * LT, 3);
        wait_to(t + 117 + 3 * LT);
        chk("err_err", int'(err), 1);
        chk("err_req_ready", int'(req_ready), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_pll_rst", int'(pll_rst), 0);
        chk("err_video_rst_n", int'(video_rst_n), 0);

        // Recovery from ERROR with mode 2.
        t = cyc;
        req_valid = 1'b1;
        req_mode  = 3'd2;
        push_ev(EV_ERR_FALL, t + 1, 3);
        push_ev(EV_PLL_RISE, t + 65, 2);
        push_ev(EV_PLL_FALL, t + 81, 2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rec_err", int'(err), 0);
        chk("rec_busy", int'(busy), 1);
        wait_to(t + 91);

        // One-cycle lock glitch during SETTLE forces a retry pulse.
        t = cyc;
        pll_locked = 1'b1;
        wait_to(t + 50);
        pll_locked = 1'b0;
        push_ev(EV_PLL_RISE, t + 53, 2);
        push_ev(EV_PLL_FALL, t + 69, 2);
        @(negedge clk);
        pll_locked = 1'b1;
        wait_to(t + 55);
        pll_locked = 1'b0;

        // Reset asserted while waiting for lock.
        wait_to(t + 89);
        reset_n = 1'b0;
        push_ev(EV_PLL_RISE, t + 90, 1);
        @(negedge clk);
        chk("wrst_pll_rst", int'(pll_rst), 1);
        chk("wrst_mode_sel", int'(mode_sel), 1);
        chk("wrst_video_rst_n", int'(video_rst_n), 0);
        chk("wrst_busy", int'(busy), 1);
        chk("wrst_req_ready", int'(req_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        push_ev(EV_PLL_FALL, cyc + 16, 1);
        wait_to(cyc + 29);
        t = cyc;
        pll_locked = 1'b1;
        push_ev(EV_VID_RISE, t + 258, 1);
        wait_to(t + 262);
        chk("fin_video_rst_n", int'(video_rst_n), 1);
        chk("fin_busy", int'(busy), 0);
        chk("fin_mode_sel", int'(mode_sel), 1);
        chk("sb_pending_events", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
